pp_switch_pipe: RTL

- Parametrised, pipelined successor to the fixed 17x68 partial-product column switch in the Wallace/Booth multiplier.
- Accepts ROWS partial products of COLS bits each and regroups them into COLS columns of ROWS bits for the compressor tree.
- Optional Booth alignment mode shifts row i left by i*SHIFT_STEP.
- Registered output and 2-entry skid buffer give valid/ready flow control at full throughput.

---
 rtl/pp_switch_pipe_if.sv | 28 ++
 rtl/pp_switch_pipe.sv | 112 +++++++++++
 2 files changed

// File: rtl/pp_switch_pipe_if.sv
// Stream bundle for the partial-product column switch: row-major input
// transactions on one side, column-major output transactions on the other.
`timescale 1ns/1ps
interface pp_switch_pipe_if #(
    parameter int ROWS = 17,
    parameter int COLS = 68
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_align;
    logic [ROWS*COLS-1:0] in_rows;
    logic                 out_valid;
    logic                 out_ready;
    logic [COLS*ROWS-1:0] out_cols;
    logic                 out_align;

    // Producer/consumer side: drives input transactions, accepts output ones
    modport master (
        output in_valid, in_align, in_rows, out_ready,
        input  in_ready, out_valid, out_cols, out_align
    );

    // Switch side
    modport slave (
        input  in_valid, in_align, in_rows, out_ready,
        output in_ready, out_valid, out_cols, out_align
    );
endinterface

// File: rtl/pp_switch_pipe.sv
// Pipelined partial-product column switch. Regroups ROWS rows of COLS bits
// into COLS columns of ROWS bits (optionally Booth-aligned, row i shifted
// left by i*SHIFT_STEP), stores the result already transposed and hands it
// out through a registered output stage backed by a one-entry skid register.
`timescale 1ns/1ps
module pp_switch_pipe #(
    parameter int ROWS       = 17,
    parameter int COLS       = 68,
    parameter int SHIFT_STEP = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pp_switch_pipe_if.slave    bus
);
    localparam int W = ROWS * COLS;

    logic [W-1:0] straight_cols;
    logic [W-1:0] aligned_cols;
    logic [W-1:0] in_cols;

    // Pure wiring: column gx bit gi picks row gi bit gx (straight) or
    // row gi bit gx - gi*SHIFT_STEP (aligned, zero below the shift).
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            for (genvar gx = 0; gx < COLS; gx++) begin : g_col
                assign straight_cols[gx*ROWS + gi] = bus.in_rows[gi*COLS + gx];
                if (gx >= gi * SHIFT_STEP) begin : g_shift
                    assign aligned_cols[gx*ROWS + gi] = bus.in_rows[gi*COLS + gx - gi*SHIFT_STEP];
                end else begin : g_zero
                    assign aligned_cols[gx*ROWS + gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign in_cols = bus.in_align ? aligned_cols : straight_cols;

    logic         main_v_reg, main_v_next;
    logic         main_a_reg, main_a_next;
    logic [W-1:0] main_d_reg, main_d_next;
    logic         skid_v_reg, skid_v_next;
    logic         skid_a_reg, skid_a_next;
    logic [W-1:0] skid_d_reg, skid_d_next;

    logic accept;
    logic main_free;

    // in_ready comes straight from the skid valid flop, so out_ready never
    // reaches it combinationally.
    assign bus.in_ready  = !skid_v_reg;
    assign bus.out_valid = main_v_reg;
    assign bus.out_cols  = main_d_reg;
    assign bus.out_align = main_a_reg;

    assign accept    = bus.in_valid && !skid_v_reg;
    assign main_free = !main_v_reg || bus.out_ready;

    // Next-state for the two-slot buffer; flush overrides every handshake.
    always_comb begin
        main_v_next = main_v_reg;
        main_a_next = main_a_reg;
        main_d_next = main_d_reg;
        skid_v_next = skid_v_reg;
        skid_a_next = skid_a_reg;
        skid_d_next = skid_d_reg;
        if (flush) begin
            main_v_next = 1'b0;
            skid_v_next = 1'b0;
        end else if (main_free) begin
            if (skid_v_reg) begin
                main_v_next = 1'b1;
                main_a_next = skid_a_reg;
                main_d_next = skid_d_reg;
                skid_v_next = accept;
                skid_a_next = bus.in_align;
                skid_d_next = in_cols;
            end else if (accept) begin
                main_v_next = 1'b1;
                main_a_next = bus.in_align;
                main_d_next = in_cols;
            end else begin
                main_v_next = 1'b0;
            end
        end else if (accept) begin
            skid_v_next = 1'b1;
            skid_a_next = bus.in_align;
            skid_d_next = in_cols;
        end
    end

    // Valid bits and the visible output register clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v_reg <= 1'b0;
            main_a_reg <= 1'b0;
            main_d_reg <= '0;
            skid_v_reg <= 1'b0;
        end else begin
            main_v_reg <= main_v_next;
            main_a_reg <= main_a_next;
            main_d_reg <= main_d_next;
            skid_v_reg <= skid_v_next;
        end
    end

    // Skid payload is qualified by skid_v_reg and needs no reset.
    always_ff @(posedge clk) begin
        skid_a_reg <= skid_a_next;
        skid_d_reg <= skid_d_next;
    end
endmodule
